shared_lock: RTL
================

SHARED_LOCK -- requirements
Module: shared_lock

Interface
REQ-001 Parameter NREQ, default 4, number of requesting processes, range 2..16.
REQ-002 Parameter TIMEOUT_W, default 8, width of the hold-timeout counter.
REQ-003 Parameter TIMEOUT, default 0, maximum hold cycles before forced release; 0 disables the timeout; must be < 2^TIMEOUT_W.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 nrst  input  1  reset, synchronous and active-low.
REQ-006 req  input  NREQ  level acquire request, bit i for requester i.
REQ-007 rel  input  NREQ  release strobe, bit i for requester i.
REQ-008 grant  output  NREQ  registered one-hot ownership; all zero when the lock is free.
REQ-009 locked  output  1  registered; 1 while any grant bit is set.
REQ-010 owner  output  max(1,clog2(NREQ))  registered index of the current or most recent owner.
REQ-011 timeout  output  1  registered single-cycle pulse on a forced release.

Function
REQ-012 The block SHALL implement a two-state machine, FREE and HELD.
REQ-013 In FREE with req nonzero, the block SHALL select the first set req bit scanning upward from (owner+1) mod NREQ and wrapping.
REQ-014 The block SHALL enter HELD on the next edge, with grant set to that bit, locked=1 and owner set to its index; grant latency is 1 cycle.
REQ-015 In FREE with req all zero, all outputs SHALL hold, and owner SHALL keep its last value.
REQ-016 In HELD, rel[owner]=1 SHALL return the block to FREE on the next edge: grant=0, locked=0, owner unchanged.
REQ-017 rel bits from non-owners SHALL be ignored in every state; any rel bit in FREE SHALL be ignored.
REQ-018 Deasserting req[owner] while in HELD SHALL NOT release the lock; only rel or timeout releases it.
REQ-019 A requester SHALL NOT be regranted in the cycle it releases: after any release the block SHALL spend at least one cycle in FREE.
REQ-020 Arbitration SHALL NOT evaluate req in the release cycle; it SHALL evaluate req only in the FREE cycle that follows.
REQ-021 A hold counter of TIMEOUT_W bits SHALL clear on entry to HELD and increment each HELD cycle.
REQ-022 With TIMEOUT!=0, when the counter equals TIMEOUT-1 and rel[owner]=0, the block SHALL force a release to FREE on the next edge and assert timeout for exactly that one cycle.
REQ-023 If rel[owner] and the timeout condition coincide, the release SHALL be treated as normal, with timeout=0.
REQ-024 With TIMEOUT=0 the counter SHALL saturate at all-ones and never force a release.
REQ-025 timeout SHALL be 0 in all other cycles.
REQ-026 grant SHALL never have more than one bit set.

Reset
REQ-027 When nrst=0 at a posedge, the block SHALL reset to: state FREE, grant=0, locked=0, owner=NREQ-1 (so requester 0 wins the first arbitration), counter=0, timeout=0.
REQ-028 Reset SHALL take priority over every other input, including mid-HELD and during a timeout cycle.
REQ-029 The first arbitration SHALL occur on the first edge after nrst returns to 1.

Verification
REQ-030 Reset, then req=4'b1111 held: grant sequence 0001, 0010, 0100, 1000, 0001, with each owner releasing one cycle after its grant and a locked=0 cycle between each grant.
REQ-031 Owner 2 held, rel=4'b1011 pulsed: no change. Then rel=4'b0100: grant=0 on the next edge, owner stays 2.
REQ-032 TIMEOUT=5, requester 1 granted, never releases: locked drops after 5 HELD cycles, and timeout=1 for exactly 1 cycle, in the same cycle as the locked=0 edge.
REQ-033 TIMEOUT=5, rel[owner] asserted in the same cycle the counter hits 4: normal release with timeout=0.
REQ-034 nrst=0 asserted while HELD by requester 3: next edge grant=0, locked=0, owner=3 (NREQ-1). With req=4'b1000 after reset, requester 3 is granted.
REQ-035 Randomised req/rel for 10k cycles: a scoreboard checks grant is one-hot or zero, locked equals |grant, and no starvation beyond NREQ grants.

Source files
------------

// File: rtl/shared_lock.sv
// shared_lock: round-robin mutual-exclusion lock with registered one-hot grant,
// release strobes and an optional hold timeout that forces a release.
`default_nettype none

module shared_lock #(
  parameter  int NREQ      = 4,
  parameter  int TIMEOUT_W = 8,
  parameter  int TIMEOUT   = 0,
  localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rel,
  output logic [NREQ-1:0] grant,
  output logic            locked,
  output logic [OW-1:0]   owner,
  output logic            timeout
);

  localparam logic STATE_FREE = 1'b0;
  localparam logic STATE_HELD = 1'b1;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  logic                 state, state_nx;
  logic [TIMEOUT_W-1:0] cnt, cnt_nx;
  logic [NREQ-1:0]      grant_nx;
  logic                 locked_nx;
  logic [OW-1:0]        owner_nx;
  logic                 timeout_nx;

  logic                 rel_own;
  logic                 to_hit;
  logic [OW-1:0]        win_idx;
  logic [OW:0]          best_d;
  logic [OW:0]          d;

  // Only the current owner's strobe counts; grant is all-zero in FREE.
  assign rel_own = |(rel & grant);
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Winner = requester with smallest circular distance after the last owner.
  always_comb begin
    best_d  = (OW+1)'(NREQ);
    win_idx = '0;
    d       = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (OW+1)'(i) + (OW+1)'(NREQ) - {1'b0, owner} - (OW+1)'(1);
      if (d >= (OW+1)'(NREQ)) d = d - (OW+1)'(NREQ);
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        win_idx = OW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= STATE_FREE;
      grant   <= '0;
      locked  <= 1'b0;
      owner   <= OW'(NREQ - 1);
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      locked  <= locked_nx;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      STATE_FREE: if (|req) state_nx = STATE_HELD;
      STATE_HELD: if (rel_own || to_hit) state_nx = STATE_FREE;
      default:    state_nx = STATE_FREE;
    endcase
  end

  always_comb begin
    grant_nx   = grant;
    locked_nx  = locked;
    owner_nx   = owner;
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
    unique case (state)
      STATE_FREE: begin
        if (|req) begin
          grant_nx  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          locked_nx = 1'b1;
          owner_nx  = win_idx;
          cnt_nx    = '0;
        end
      end
      STATE_HELD: begin
        if (rel_own || to_hit) begin
          grant_nx   = '0;
          locked_nx  = 1'b0;
          timeout_nx = ~rel_own;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        grant_nx  = '0;
        locked_nx = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
